// File: rtl/nf_10g_tx_arbiter.sv
// Two-input, frame-granular arbiter in front of the 10G MAC TX stream.
// A granted source that stalls mid-frame is cut off with an underrun beat and the remainder of its frame is drained.
module nf_10g_tx_arbiter #(
    parameter int C_DATA_WIDTH    = 64,
    parameter int C_STALL_TIMEOUT = 16,
    parameter int C_CNT_WIDTH     = 32
) (
    input  logic                      clk156,
    input  logic                      areset_clk156,
    input  logic [C_DATA_WIDTH-1:0]   s0_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] s0_axis_tkeep,
    input  logic                      s0_axis_tuser,
    input  logic                      s0_axis_tvalid,
    input  logic                      s0_axis_tlast,
    output logic                      s0_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]   s1_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] s1_axis_tkeep,
    input  logic                      s1_axis_tuser,
    input  logic                      s1_axis_tvalid,
    input  logic                      s1_axis_tlast,
    output logic                      s1_axis_tready,
    output logic [C_DATA_WIDTH-1:0]   m_axis_mac_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_mac_tkeep,
    output logic                      m_axis_mac_tuser,
    output logic                      m_axis_mac_tvalid,
    output logic                      m_axis_mac_tlast,
    input  logic                      m_axis_mac_tready,
    input  logic                      cfg_strict_prio,
    output logic [C_CNT_WIDTH-1:0]    pkt_cnt0,
    output logic [C_CNT_WIDTH-1:0]    pkt_cnt1,
    output logic [15:0]               abort_cnt
);
    localparam int         KW        = C_DATA_WIDTH / 8;
    localparam logic [7:0] STALL_LIM = 8'(C_STALL_TIMEOUT);

    typedef enum logic [1:0] {IDLE, PKT, ABORT, DRAIN} state_t;

    state_t                 state_q;
    logic                   grant_q;
    logic                   last_grant_q;
    logic [7:0]             stall_q;
    logic [C_CNT_WIDTH-1:0] pkt_cnt0_q;
    logic [C_CNT_WIDTH-1:0] pkt_cnt1_q;
    logic [15:0]            abort_cnt_q;

    logic       grant_d;
    logic [7:0] stall_d;
    logic       g_valid;
    logic       g_last;
    logic [1:0] s_ready;

    assign g_valid = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign g_last  = grant_q ? s1_axis_tlast  : s0_axis_tlast;
    assign stall_d = stall_q + 8'd1;

    // Only one port requesting takes it; a tie goes to port 0 (strict) or away from the last winner.
    always_comb begin
        grant_d = s1_axis_tvalid;
        if (s0_axis_tvalid && s1_axis_tvalid)
            grant_d = cfg_strict_prio ? 1'b0 : ~last_grant_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign s_ready[gi] = !areset_clk156 && (grant_q == gi[0]) &&
                                 ((state_q == PKT && m_axis_mac_tready) || state_q == DRAIN);
        end
    endgenerate

    assign s0_axis_tready = s_ready[0];
    assign s1_axis_tready = s_ready[1];

    // Outputs are forced low while reset is held, even before the state register has cleared.
    always_comb begin
        m_axis_mac_tdata  = '0;
        m_axis_mac_tkeep  = '0;
        m_axis_mac_tuser  = 1'b0;
        m_axis_mac_tvalid = 1'b0;
        m_axis_mac_tlast  = 1'b0;
        if (!areset_clk156) begin
            case (state_q)
                PKT: begin
                    m_axis_mac_tdata  = grant_q ? s1_axis_tdata  : s0_axis_tdata;
                    m_axis_mac_tkeep  = grant_q ? s1_axis_tkeep  : s0_axis_tkeep;
                    m_axis_mac_tuser  = grant_q ? s1_axis_tuser  : s0_axis_tuser;
                    m_axis_mac_tvalid = g_valid;
                    m_axis_mac_tlast  = g_last;
                end
                ABORT: begin
                    m_axis_mac_tkeep  = KW'(1);
                    m_axis_mac_tuser  = 1'b1;
                    m_axis_mac_tvalid = 1'b1;
                    m_axis_mac_tlast  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk156) begin
        if (areset_clk156) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            stall_q      <= '0;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
            abort_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    stall_q <= '0;
                    if (s0_axis_tvalid || s1_axis_tvalid) begin
                        grant_q <= grant_d;
                        state_q <= PKT;
                    end
                end
                PKT: begin
                    if (g_valid) begin
                        stall_q <= '0;
                        if (m_axis_mac_tready && g_last) begin
                            if (grant_q) pkt_cnt1_q <= pkt_cnt1_q + 1'b1;
                            else         pkt_cnt0_q <= pkt_cnt0_q + 1'b1;
                            last_grant_q <= grant_q;
                            state_q      <= IDLE;
                        end
                    end else begin
                        stall_q <= stall_d;
                        if (stall_d == STALL_LIM)
                            state_q <= ABORT;
                    end
                end
                ABORT: begin
                    if (m_axis_mac_tready) begin
                        if (abort_cnt_q != 16'hFFFF)
                            abort_cnt_q <= abort_cnt_q + 16'd1;
                        stall_q <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (g_valid && g_last) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pkt_cnt0  = pkt_cnt0_q;
    assign pkt_cnt1  = pkt_cnt1_q;
    assign abort_cnt = abort_cnt_q;
endmodule

// File: doc/nf_10g_tx_arbiter.md
Name: nf_10g_tx_arbiter

Overview:
- Packet-level two-input arbiter sharing one 10G MAC TX stream (64b @ clk156) between two requesters, e.g. the low-latency order-entry engine (port 0) and the pipeline/DMA TX path (port 1).
- Sits between the requesters and the MAC `s_axis_tx_*` interface.
- Grant is held for a whole frame. Arbitration is round-robin or strict priority.
- A source that stalls mid-frame is aborted with an underrun beat, so the MAC never waits on a stalled source.

Parameters:
- C_DATA_WIDTH, 64, stream data width; tkeep is C_DATA_WIDTH/8.
- C_STALL_TIMEOUT, 16, consecutive mid-frame cycles with granted tvalid=0 that trigger an abort (range 1..255).
- C_CNT_WIDTH, 32, width of per-port packet counters.

Ports:
- clk156  in  1  156.25 MHz core clock; the only clock.
- areset_clk156  in  1  synchronous, active-high reset.
- s0_axis_tdata  in  64  port 0 data.
- s0_axis_tkeep  in  8  port 0 byte enables.
- s0_axis_tuser  in  1  port 0 underrun flag.
- s0_axis_tvalid  in  1  port 0 valid.
- s0_axis_tlast  in  1  port 0 last.
- s0_axis_tready  out  1  port 0 ready.
- s1_axis_tdata/tkeep/tuser/tvalid/tlast/tready  as s0, for port 1.
- m_axis_mac_tdata  out  64  to MAC.
- m_axis_mac_tkeep  out  8  to MAC.
- m_axis_mac_tuser  out  1  to MAC; 1 = underrun/abort.
- m_axis_mac_tvalid  out  1  to MAC.
- m_axis_mac_tlast  out  1  to MAC.
- m_axis_mac_tready  in  1  from MAC.
- cfg_strict_prio  in  1  1 = port 0 always wins; 0 = round-robin.
- pkt_cnt0  out  32  frames completed on port 0.
- pkt_cnt1  out  32  frames completed on port 1.
- abort_cnt  out  16  frames aborted on stall timeout.

Behaviour:
- Reset: all registers update on posedge clk156 only.
  - state=IDLE, grant=0, last_grant=1 (so port 0 wins first tie), stall counter=0, all counters=0.
  - During and after reset: all m_axis_mac_* outputs 0, both s*_tready 0.
  - Reset mid-frame truncates silently with no abort beat; the MAC is reset alongside.
- States: IDLE, PKT, ABORT, DRAIN.
- IDLE: outputs 0, tready 0.
  - Requester r = tvalid of each port.
  - Only one port valid: grant it.
  - Both valid and cfg_strict_prio=1: grant port 0.
  - Both valid and cfg_strict_prio=0: grant ~last_grant.
  - Grant registered; go to PKT next cycle, so there is 1 bubble cycle per frame.
  - cfg_strict_prio is sampled only in IDLE.
- PKT: combinational pass-through, zero latency.
  - m_axis_mac_{tdata,tkeep,tuser,tlast,tvalid} = granted source.
  - Granted tready = m_axis_mac_tready. Other source tready = 0.
  - Beat accepted = granted tvalid & m_axis_mac_tready.
  - Accepted beat with tlast: pkt_cnt[grant]+1 (wraps modulo 2^32), last_grant<=grant, go to IDLE.
- Stall counter (8b), counting in PKT only:
  - Cycle with granted tvalid=0: increment.
  - Cycle with granted tvalid=1: clear.
  - m_axis_mac_tready=0 never counts as a stall.
  - Counter reaches C_STALL_TIMEOUT (count == C_STALL_TIMEOUT after increment): go to ABORT.
  - A valid beat in the same cycle takes precedence and clears the counter, so no abort.
- ABORT: emit one synthetic beat, held until m_axis_mac_tready.
  - Beat: tvalid=1, tlast=1, tuser=1, tkeep=8'h01, tdata=0.
  - Source tready = 0.
  - On handshake: abort_cnt+1 (saturates at 16'hFFFF), counter clear, go to DRAIN.
- DRAIN: discard the rest of the aborted frame.
  - m_axis_mac_tvalid=0. Granted tready=1. Other tready=0.
  - On granted tvalid & tlast: last_grant<=grant, go to IDLE.
  - DRAIN has no timeout; it waits indefinitely for tlast.
- Aborted frames never increment pkt_cnt.
- A single-beat frame (tlast on first beat) is legal: PKT lasts 1 cycle if m_axis_mac_tready=1.
- Source tuser=1 passes through unchanged and the frame still counts in pkt_cnt.
- No cycle has both s*_tready high at once.

Test Plan:
1. Port 0 only, 3 frames of 8 beats, m_tready=1 → MAC sees 24 beats in order, 1 idle cycle between frames, pkt_cnt0=3, pkt_cnt1=0.
2. Both ports continuously valid, cfg_strict_prio=0, 4-beat frames → grants alternate 0,1,0,1; after 10 frames pkt_cnt0=5 and pkt_cnt1=5; no interleaving within a frame.
3. Same traffic as 2 with cfg_strict_prio=1 → only port 0 is served; pkt_cnt1 stays 0 while port 0 keeps tvalid high.
4. Port 1 sends 2 beats, then holds tvalid=0 for 16 cycles with C_STALL_TIMEOUT=16, then sends 3 beats ending in tlast → MAC sees 2 beats then an abort beat (tuser=1, tlast=1, tkeep=01); the 3 beats are consumed with no MAC output; abort_cnt=1, pkt_cnt1=0.
5. m_axis_mac_tready=0 for 40 cycles mid-frame with the source valid → no abort, frame completes intact once ready returns.
6. Assert areset_clk156 for 1 cycle mid-frame in PKT → next cycle state=IDLE, all outputs 0, counters 0; then port 0 wins a simultaneous request (last_grant=1).
